// File: rtl/astropix_frame_reader_pkg.sv
// Shared constants for the AstroPix lane frame reader: FSM encodings, frame layout, error bits.
package astropix_frame_reader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StLen     = 3'd0;
  localparam state_t StId      = 3'd1;
  localparam state_t StHdr     = 3'd2;
  localparam state_t StPayload = 3'd3;
  localparam state_t StTs      = 3'd4;
  localparam state_t StDrop    = 3'd5;
  localparam state_t StOut     = 3'd6;

  localparam logic [7:0]  LenOffset = 8'd6;
  localparam int unsigned TsBytes   = 4;

  localparam int unsigned ErrLenBit   = 0;
  localparam int unsigned ErrEarlyBit = 1;
  localparam int unsigned ErrFrameBit = 2;

  localparam logic [7:0] IdleByte = 8'h3D;

  // LEN byte a well-formed frame must carry for a given payload count.
  function automatic logic [7:0] expected_len(input logic [2:0] plen);
    return {5'd0, plen} + LenOffset;
  endfunction

endpackage

// File: rtl/astropix_frame_reader.sv
// Parses framed AstroPix lane bytes into one record per frame with error flags.
// Optional ASTROPIX_FRAME_READER_ERRCNT_EN adds a saturating error-record counter.
module astropix_frame_reader
  import astropix_frame_reader_pkg::*;
#(
  parameter int unsigned LANE_COUNT  = 8,
  parameter int unsigned MAX_PAYLOAD = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic                     s_axis_tlast,
  output logic [7:0]               m_lane_id,
  output logic [7:0]               m_header,
  output logic [8*MAX_PAYLOAD-1:0] m_payload,
  output logic [2:0]               m_payload_len,
  output logic [31:0]              m_timestamp,
  output logic [2:0]               m_err,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     stat_frame_ok,
  output logic                     stat_frame_err,
  input  logic                     cfg_flush
`ifdef ASTROPIX_FRAME_READER_ERRCNT_EN
  ,
  output logic [15:0]              stat_err_count
`endif
);

  state_t                   state_q, state_d;
  logic                     rdy_q;
  logic [7:0]               len_q, len_d;
  logic [7:0]               lane_q, lane_d;
  logic [7:0]               hdr_q, hdr_d;
  logic [8*MAX_PAYLOAD-1:0] payload_q, payload_d;
  logic [31:0]              ts_q, ts_d;
  logic [2:0]               err_q, err_d;
  logic [2:0]               idx_q, idx_d;
  logic [1:0]               ts_cnt_q, ts_cnt_d;
  logic                     ok_q, ok_d;
  logic                     errp_q, errp_d;
  logic                     accept;
  logic                     clear_rec;

  // tready held low through reset and for the cycle reset releases.
  assign s_axis_tready = rdy_q && (state_q != StOut);
  assign accept        = s_axis_tvalid && s_axis_tready;

  assign m_valid        = (state_q == StOut);
  assign m_lane_id      = lane_q;
  assign m_header       = hdr_q;
  assign m_payload      = payload_q;
  assign m_payload_len  = hdr_q[2:0];
  assign m_timestamp    = ts_q;
  assign m_err          = err_q;
  assign stat_frame_ok  = ok_q;
  assign stat_frame_err = errp_q;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    lane_d    = lane_q;
    hdr_d     = hdr_q;
    payload_d = payload_q;
    ts_d      = ts_q;
    err_d     = err_q;
    idx_d     = idx_q;
    ts_cnt_d  = ts_cnt_q;
    ok_d      = 1'b0;
    errp_d    = 1'b0;
    clear_rec = 1'b0;

    if (cfg_flush) begin
      state_d   = StLen;
      clear_rec = 1'b1;
    end else begin
      unique case (state_q)
        StLen: begin
          if (accept) begin
            len_d = s_axis_tdata;
            if (s_axis_tlast) begin
              err_d[ErrEarlyBit] = 1'b1;
              state_d            = StOut;
            end else begin
              state_d = StId;
            end
          end
        end
        StId: begin
          if (accept) begin
            lane_d = s_axis_tdata;
            if ({24'd0, s_axis_tdata} >= LANE_COUNT) err_d[ErrFrameBit] = 1'b1;
            if (s_axis_tlast) begin
              err_d[ErrEarlyBit] = 1'b1;
              state_d            = StOut;
            end else begin
              state_d = StHdr;
            end
          end
        end
        StHdr: begin
          if (accept) begin
            hdr_d = s_axis_tdata;
            if (len_q != expected_len(s_axis_tdata[2:0])) err_d[ErrLenBit] = 1'b1;
            if (s_axis_tlast) begin
              err_d[ErrEarlyBit] = 1'b1;
              state_d            = StOut;
            end else if (len_q != expected_len(s_axis_tdata[2:0])) begin
              state_d = StDrop;
            end else if (s_axis_tdata[2:0] != 3'd0) begin
              state_d = StPayload;
            end else begin
              state_d = StTs;
            end
          end
        end
        StPayload: begin
          if (accept) begin
            for (int unsigned k = 0; k < MAX_PAYLOAD; k++) begin
              if (idx_q == 3'(k)) payload_d[8*k +: 8] = s_axis_tdata;
            end
            idx_d = idx_q + 3'd1;
            if (s_axis_tlast) begin
              err_d[ErrEarlyBit] = 1'b1;
              state_d            = StOut;
            end else if (idx_q == hdr_q[2:0] - 3'd1) begin
              state_d = StTs;
            end
          end
        end
        StTs: begin
          if (accept) begin
            ts_d[{ts_cnt_q, 3'b000} +: 8] = s_axis_tdata;
            ts_cnt_d = ts_cnt_q + 2'd1;
            if (ts_cnt_q == 2'(TsBytes - 1)) begin
              if (s_axis_tlast) begin
                state_d = StOut;
              end else begin
                err_d[ErrFrameBit] = 1'b1;
                state_d            = StDrop;
              end
            end else if (s_axis_tlast) begin
              err_d[ErrEarlyBit] = 1'b1;
              state_d            = StOut;
            end
          end
        end
        StDrop: begin
          if (accept && s_axis_tlast) state_d = StOut;
        end
        StOut: begin
          if (m_ready) begin
            state_d   = StLen;
            clear_rec = 1'b1;
          end
        end
        default: begin
          state_d   = StLen;
          clear_rec = 1'b1;
        end
      endcase

      // Stat pulses are registered so they coincide with the first m_valid cycle.
      if (state_d == StOut && state_q != StOut) begin
        ok_d   = (err_d == 3'd0);
        errp_d = (err_d != 3'd0);
      end
    end

    if (clear_rec) begin
      len_d     = '0;
      lane_d    = '0;
      hdr_d     = '0;
      payload_d = '0;
      ts_d      = '0;
      err_d     = '0;
      idx_d     = '0;
      ts_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StLen;
      rdy_q     <= 1'b0;
      len_q     <= '0;
      lane_q    <= '0;
      hdr_q     <= '0;
      payload_q <= '0;
      ts_q      <= '0;
      err_q     <= '0;
      idx_q     <= '0;
      ts_cnt_q  <= '0;
      ok_q      <= 1'b0;
      errp_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rdy_q     <= 1'b1;
      len_q     <= len_d;
      lane_q    <= lane_d;
      hdr_q     <= hdr_d;
      payload_q <= payload_d;
      ts_q      <= ts_d;
      err_q     <= err_d;
      idx_q     <= idx_d;
      ts_cnt_q  <= ts_cnt_d;
      ok_q      <= ok_d;
      errp_q    <= errp_d;
    end
  end

`ifdef ASTROPIX_FRAME_READER_ERRCNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cfg_flush) begin
      cnt_d = '0;
    end else if (errp_d && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign stat_err_count = cnt_q;
`endif

endmodule
